// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low row drive, debounces whole-matrix
// frames and reports single fresh presses as a 4-bit code with a one-cycle strobe.
module keypad_scan #(
  parameter int SCAN_DIV = 4096,
  parameter int DEBOUNCE = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [3:0]  ROW,
  input  logic [3:0]  COL,
  output logic [3:0]  KEY,
  output logic        VALID,
  output logic        PRESSED,
  output logic [15:0] KEYMAP
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SAME_MAX = CW'(DEBOUNCE - 1);

  function automatic logic onehot16(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

  function automatic logic [3:0] bit_index16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [DW-1:0] div_r;
  logic [1:0]    row_r;
  logic [3:0]    row_drv_r;
  logic [3:0]    sync1_r, sync2_r;
  logic [15:0]   frame_r, prev_frame_r, keymap_r;
  logic [CW-1:0] same_cnt_r;
  logic [3:0]    key_r;
  logic          valid_r, pressed_r;

  logic          tick_s, frame_done_s, accept_s;
  logic [3:0]    col_s;
  logic [1:0]    row_next_s;
  logic [15:0]   frame_s;
  logic [CW-1:0] same_next_s;

  // Assemble the frame with the current row's sample and evaluate debounce state
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    col_s      = ~sync2_r;
    row_next_s = row_r + 2'd1;
    frame_s    = frame_r;
    case (row_r)
      2'd0:    frame_s[3:0]   = col_s;
      2'd1:    frame_s[7:4]   = col_s;
      2'd2:    frame_s[11:8]  = col_s;
      2'd3:    frame_s[15:12] = col_s;
      default: frame_s        = frame_r;
    endcase
    frame_done_s = tick_s && (row_r == 2'd3);
    if (frame_s != prev_frame_r) begin
      same_next_s = '0;
    end else if (same_cnt_r == SAME_MAX) begin
      same_next_s = same_cnt_r;
    end else begin
      same_next_s = same_cnt_r + CW'(1);
    end
    accept_s = frame_done_s && (same_next_s == SAME_MAX) && (frame_s != keymap_r);
  end

  // Scan divider, row walk, synchronizer, debounce history and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_r        <= '0;
      row_r        <= 2'd0;
      row_drv_r    <= 4'b1110;
      sync1_r      <= 4'hF;
      sync2_r      <= 4'hF;
      frame_r      <= 16'h0000;
      prev_frame_r <= 16'h0000;
      same_cnt_r   <= '0;
      keymap_r     <= 16'h0000;
      key_r        <= 4'h0;
      valid_r      <= 1'b0;
      pressed_r    <= 1'b0;
    end else begin
      sync1_r <= COL;
      sync2_r <= sync1_r;
      valid_r <= 1'b0;
      div_r   <= tick_s ? '0 : div_r + DW'(1);
      if (tick_s) begin
        frame_r   <= frame_s;
        row_r     <= row_next_s;
        row_drv_r <= ~(4'b0001 << row_next_s);
      end
      if (frame_done_s) begin
        prev_frame_r <= frame_s;
        same_cnt_r   <= same_next_s;
      end
      // Only a fresh single press out of an idle matrix yields a key code
      if (accept_s) begin
        keymap_r  <= frame_s;
        pressed_r <= |frame_s;
        if ((keymap_r == 16'h0000) && onehot16(frame_s)) begin
          key_r   <= bit_index16(frame_s);
          valid_r <= 1'b1;
        end
      end
    end
  end

  assign ROW     = row_drv_r;
  assign KEY     = key_r;
  assign VALID   = valid_r;
  assign PRESSED = pressed_r;
  assign KEYMAP  = keymap_r;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad model drives COL from ROW, a scoreboard
// queue holds expected key reports and a monitor checks every VALID strobe.
module tb_keypad_scan;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [3:0]  ROW, COL, KEY;
  logic        VALID, PRESSED;
  logic [15:0] KEYMAP;

  logic [15:0] keys = 16'h0000;
  logic        col_force = 1'b0;
  logic [3:0]  col_m;
  int          cyc;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] map;
    int          at;
  } exp_t;
  exp_t q[$];

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .CLK(CLK), .RESET(RESET), .ROW(ROW), .COL(COL),
    .KEY(KEY), .VALID(VALID), .PRESSED(PRESSED), .KEYMAP(KEYMAP)
  );

  always #5 CLK = ~CLK;

  // Keypad model: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!ROW[r] && keys[r*4+c]) col_m[c] = 1'b0;
  end
  assign COL = col_force ? 4'h0 : col_m;

  always @(posedge CLK or negedge RESET)
    if (!RESET) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (n) @(negedge CLK);
    chk("rst_valid", VALID, 0);
    chk("rst_keymap", KEYMAP, 16'h0000);
    RESET = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET && VALID) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", {28'h0, KEY}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("valid_key", KEY, e.key);
          chk("valid_keymap", KEYMAP, e.map);
          chk("valid_pressed", PRESSED, 1);
          chk("valid_cycle", cyc, e.at);
        end
      end
    end
  endtask

  initial begin
    logic [3:0] er;
    fork
      monitor();
    join_none

    // Reset values with every column pulled low
    col_force = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_row", ROW, 4'b1110);
    chk("reset_key", KEY, 0);
    chk("reset_valid", VALID, 0);
    chk("reset_pressed", PRESSED, 0);
    chk("reset_keymap", KEYMAP, 16'h0000);
    col_force = 1'b0;
    RESET = 1'b1;
    for (int k = 0; k < 16; k++) begin
      er = ~(4'b0001 << (k / 4));
      chk("row_seq", ROW, er);
      @(negedge CLK);
    end

    // Single press of key 6 held from the first frame
    keys = 16'h0040;
    pulse_reset(3);
    q.push_back('{key: 4'd6, map: 16'h0040, at: 32});
    wait_until(40);
    chk("t2_reported", q.size(), 0);
    wait_until(192);
    chk("t2_held_pressed", PRESSED, 1);
    chk("t2_held_keymap", KEYMAP, 16'h0040);
    keys = 16'h0000;
    wait_until(223);
    chk("t2_release_early", KEYMAP, 16'h0040);
    wait_until(224);
    chk("t2_release_keymap", KEYMAP, 16'h0000);
    chk("t2_release_pressed", PRESSED, 0);

    // Bouncing key 15, then held
    q.push_back('{key: 4'd15, map: 16'h8000, at: 320});
    for (int j = 0; j < 10; j++) begin
      wait_until(240 + 5 * j);
      keys = (j % 2 == 0) ? 16'h8000 : 16'h0000;
    end
    wait_until(288);
    keys = 16'h8000;
    wait_until(321);
    chk("t3_reported", q.size(), 0);

    // Multi-key press and partial release
    keys = 16'h0000;
    wait_until(352);
    chk("t4_idle_keymap", KEYMAP, 16'h0000);
    keys = 16'h0021;
    wait_until(385);
    chk("t4_multi_keymap", KEYMAP, 16'h0021);
    chk("t4_multi_pressed", PRESSED, 1);
    chk("t4_multi_key_hold", KEY, 15);
    wait_until(400);
    keys = 16'h0001;
    wait_until(433);
    chk("t4_partial_keymap", KEYMAP, 16'h0001);
    chk("t4_partial_key_hold", KEY, 15);

    // Sequential keys 3 then 12
    wait_until(448);
    keys = 16'h0000;
    wait_until(480);
    keys = 16'h0008;
    q.push_back('{key: 4'd3, map: 16'h0008, at: 512});
    wait_until(528);
    keys = 16'h0000;
    wait_until(560);
    keys = 16'h1000;
    q.push_back('{key: 4'd12, map: 16'h1000, at: 592});
    wait_until(608);
    chk("t5_reported", q.size(), 0);

    // Reset in the middle of debouncing key 9
    keys = 16'h0000;
    wait_until(640);
    keys = 16'h0200;
    wait_until(660);
    chk("t6_not_yet", KEYMAP, 16'h0000);
    pulse_reset(3);
    q.push_back('{key: 4'd9, map: 16'h0200, at: 32});
    wait_until(31);
    chk("t6_no_early_valid", VALID, 0);
    wait_until(40);
    chk("t6_reported", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad reader for the board's 4x4 key array: the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad row low at a time, samples the active-low columns, debounces whole-matrix snapshots, and reports single key presses as a 4-bit code with a one-cycle strobe. It sits beside the counter/display logic and feeds key codes to control logic, for example for setting or clearing counters.

## Interface
- `SCAN_DIV`, default 4096: CLK cycles per row period. Must be at least 4.
- `DEBOUNCE`, default 4: number of consecutive identical full-matrix frames required before a frame is accepted as stable. Must be at least 2.
- `CLK` input, 1 bit: system clock. All logic is on the rising edge.
- `RESET` input, 1 bit: reset, asynchronous, active-low.
- `ROW` output, 4 bits: row drive, active-low, one-hot-zero.
- `COL` input, 4 bits: column sense, active-low, with external pull-ups. Asynchronous to CLK.
- `KEY` output, 4 bits: code of the last accepted key, `row*4 + col`.
- `VALID` output, 1 bit: one-cycle strobe when `KEY` is updated.
- `PRESSED` output, 1 bit: high while the stable frame has any key down.
- `KEYMAP` output, 16 bits: current stable frame, active-high. Bit `row*4+col`.

## Operation
- `COL` passes through a 2-flop synchronizer before use.
- Divider `div`:
  - Counts 0..SCAN_DIV-1, then wraps.
  - `tick` is asserted when `div == SCAN_DIV-1`.
- Row counter `r`, 0..3:
  - `ROW = ~(1 << r)`.
  - On `tick`, `~COL_sync` is stored into frame bits `[4r+3:4r]`, then `r` advances (3 wraps to 0).
  - Sampling at the end of the row period gives `COL` at least SCAN_DIV-2 cycles to settle through the synchronizer.
- Frame completion on the `tick` with `r==3` (the assembled frame includes the row-3 sample just taken):
  - If the frame equals `prev_frame`, `same_cnt` increments, saturating at DEBOUNCE-1.
  - Otherwise `same_cnt` is set to 0.
  - `prev_frame` is set to the frame.
  - The frame is accepted as stable when `same_cnt` becomes DEBOUNCE-1, i.e. on the DEBOUNCE-th identical frame.
- Acceptance, applied only when the accepted frame differs from `KEYMAP`:
  - `KEYMAP` takes the accepted frame.
  - `PRESSED` takes `|frame`.
  - If the old `KEYMAP` was zero and the new frame has exactly one bit set: `KEY` takes that bit's index and `VALID` pulses.
  - Multiple keys, or a change while a key is already held (rollover), update `KEYMAP`/`PRESSED` only. There is no `VALID` and `KEY` holds.
  - A release to all-zero clears `PRESSED`, with no `VALID`.
- An accepted frame identical to `KEYMAP` produces no action. A held key therefore never repeats `VALID`.
- Bounce: any differing frame restarts the count, so a bouncing key is reported once, after it settles.
- Reset: asynchronous assertion clears everything at once. Scanning restarts from row 0 after release.

## Timing
- Reset values:
  - `ROW=4'b1110`, `KEY=0`, `VALID=0`, `PRESSED=0`, `KEYMAP=0`.
  - `div=0`, `r=0`, `same_cnt=0`, `prev_frame=0`, synchronizer flops all-ones (keys released).
- One frame is 4*SCAN_DIV cycles.
- Outputs `KEY`, `VALID`, `PRESSED` and `KEYMAP` are registered. They change in the cycle after the completing `tick`.
- `VALID` is high for exactly 1 CLK.
- Press latency, for a press stable before a frame starts: DEBOUNCE frames + 1 cycle. Worst case, for a press landing just after its row was sampled: DEBOUNCE+1 frames + 1 cycle.
- Release latency is the same as press latency.
- Reset mid-frame discards the partial frame and the debounce history. No `VALID` is emitted after reset until DEBOUNCE fresh frames match.
- `div` and `r` free-run. Debounce activity never stalls scanning.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2, so a frame is 16 cycles.
1. Reset: hold `RESET=0` with `COL=0000` -> all outputs at their reset values. After release, `ROW` sequences 1110, 1101, 1011, 0111, each held 4 cycles.
2. Single press: model key row1/col2 (`COL[2]` low while `ROW[1]` low), held from frame start -> `VALID` pulses once, with `KEY=6`, `PRESSED=1`, `KEYMAP=16'h0040`, at 2 frames + 1 cycle. No further `VALID` over 10 more frames. After release, `PRESSED=0` and `KEYMAP=0` two frames later.
3. Bounce: key 15 toggling every 5 cycles for 3 frames, then held -> no `VALID` during the bounce. Exactly one `VALID` with `KEY=15` after 2 clean frames.
4. Multi-key: keys 0 and 5 pressed together -> `KEYMAP=16'h0021`, `PRESSED=1`, no `VALID`, `KEY` unchanged. Releasing key 5 with key 0 still held -> `KEYMAP=16'h0001`, still no `VALID`.
5. Sequential keys: press/release key 3, then press key 12 -> two `VALID` pulses, with `KEY=3` then `KEY=12`.
6. Reset mid-debounce: key 9 seen for 1 frame, then assert `RESET` for 3 cycles -> no `VALID`. After release, key 9 still held gives `VALID` with `KEY=9` only after 2 full frames.
